// File: rtl/mux_8_1_serializer.sv
// Parallel-to-serial transmitter: captures a WIDTH-bit word on valid/ready and shifts it out one bit per clock.
// Optional feature macro: PARITY_EN appends an even-parity bit after each frame.
module mux_8_1_serializer #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             y,
    output logic             y_valid,
    output logic [SEL_W-1:0] s,
    output logic             frame_done
);

`ifdef PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shadow;
    logic [SEL_W-1:0]   r_s;
    logic               r_y;
    logic               r_y_valid;
    logic               r_in_ready;
    logic               r_frame_done;

    logic               w_accept;
    logic [SEL_W-1:0]   w_next_s;
    logic               w_first_bit;
    logic               w_next_bit;

    // Map the select count onto the shadow bit index for the chosen bit order.
    function automatic logic [SEL_W-1:0] bit_idx(input logic [SEL_W-1:0] sel);
        return MSB_FIRST ? (LAST_SEL - sel) : sel;
    endfunction

    assign w_accept    = in_valid & r_in_ready;
    assign w_next_s    = r_s + 1'b1;
    assign w_first_bit = I[bit_idx('0)];
    assign w_next_bit  = r_shadow[bit_idx(w_next_s)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shadow     <= '0;
            r_s          <= '0;
            r_y          <= 1'b0;
            r_y_valid    <= 1'b0;
            r_in_ready   <= 1'b1;
            r_frame_done <= 1'b0;
        end else if (w_accept) begin
            // Accept only happens in IDLE or on the final cycle of a frame, so a new
            // frame always starts here, giving zero-gap back-to-back transfers.
            r_state      <= ST_SHIFT;
            r_shadow     <= I;
            r_s          <= '0;
            r_y          <= w_first_bit;
            r_y_valid    <= 1'b1;
            r_in_ready   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_s       <= '0;
                    r_y       <= 1'b0;
                    r_y_valid <= 1'b0;
                end
                ST_SHIFT: begin
                    if (r_s != LAST_SEL) begin
                        r_s <= w_next_s;
                        r_y <= w_next_bit;
`ifdef PARITY_EN
                        r_frame_done <= 1'b0;
                        r_in_ready   <= 1'b0;
`else
                        r_frame_done <= (w_next_s == LAST_SEL);
                        r_in_ready   <= (w_next_s == LAST_SEL);
`endif
                    end else begin
`ifdef PARITY_EN
                        r_state      <= ST_PARITY;
                        r_y          <= ^r_shadow;
                        r_frame_done <= 1'b1;
                        r_in_ready   <= 1'b1;
`else
                        r_state      <= ST_IDLE;
                        r_s          <= '0;
                        r_y          <= 1'b0;
                        r_y_valid    <= 1'b0;
                        r_frame_done <= 1'b0;
                        r_in_ready   <= 1'b1;
`endif
                    end
                end
`ifdef PARITY_EN
                ST_PARITY: begin
                    r_state      <= ST_IDLE;
                    r_s          <= '0;
                    r_y          <= 1'b0;
                    r_y_valid    <= 1'b0;
                    r_frame_done <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
`endif
                default: begin
                    r_state      <= ST_IDLE;
                    r_s          <= '0;
                    r_y          <= 1'b0;
                    r_y_valid    <= 1'b0;
                    r_frame_done <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign y          = r_y;
    assign y_valid    = r_y_valid;
    assign s          = r_s;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mux_8_1_serializer.sv
// Directed bench for mux_8_1_serializer: reset, single frames, back-to-back, ignored mid-frame valid, mid-frame reset.
module tb_mux_8_1_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] I = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       y;
    logic       y_valid;
    logic [2:0] s;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    mux_8_1_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .I          (I),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .y          (y),
        .y_valid    (y_valid),
        .s          (s),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"},   32'(in_ready),   32'd1);
        chk({tag, ".y_valid"},    32'(y_valid),    32'd0);
        chk({tag, ".y"},          32'(y),          32'd0);
        chk({tag, ".s"},          32'(s),          32'd0);
        chk({tag, ".frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic chk_cycle(input string tag, input int exp_s, input bit exp_y, input bit exp_last);
        chk({tag, ".y_valid"},    32'(y_valid),    32'd1);
        chk({tag, ".s"},          32'(s),          32'(exp_s));
        chk({tag, ".y"},          32'(y),          32'(exp_y));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(exp_last));
        chk({tag, ".in_ready"},   32'(in_ready),   32'(exp_last));
    endtask

    // Hand-computed LSB-first bit sequences.
    bit exp_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit exp_96 [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    bit exp_f0 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    bit exp_5a [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    bit exp_07 [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 1};

    initial begin
        // Test 1: reset, then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle($sformatf("t1.idle%0d", i));
            $display("t1 idle cycle %0d: in_ready=%0b y_valid=%0b", i, in_ready, y_valid);
        end

`ifndef PARITY_EN
        // Test 2: single frame 8'hA5
        I = 8'hA5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; I = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk_cycle($sformatf("t2.b%0d", k), k, exp_a5[k], k == 7);
            $display("t2 bit s=%0d y=%0b frame_done=%0b", s, y, frame_done);
            @(negedge clk);
        end
        chk_idle("t2.after");

        // Test 3: back-to-back FF then 00 with in_valid held
        I = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        I = 8'h00;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) in_valid = 1'b0;
            chk_cycle($sformatf("t3.b%0d", k), k % 8, k < 8, (k % 8) == 7);
            $display("t3 bit %0d s=%0d y=%0b", k, s, y);
            @(negedge clk);
        end
        chk_idle("t3.after");

        // Test 4: in_valid pulse with 8'h3C at s=3 must be ignored
        I = 8'h96; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin I = 8'h3C; in_valid = 1'b1; end
            if (k == 4) begin in_valid = 1'b0; I = 8'h00; end
            chk_cycle($sformatf("t4.b%0d", k), k, exp_96[k], k == 7);
            $display("t4 bit s=%0d y=%0b in_valid=%0b", s, y, in_valid);
            @(negedge clk);
        end
        chk_idle("t4.after");

        // Test 5: async reset at s=4 during 8'hF0, then a whole 8'h5A frame
        I = 8'hF0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_cycle($sformatf("t5.b%0d", k), k, exp_f0[k], 1'b0);
            if (k < 4) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk_idle("t5.rst");
        $display("t5 reset mid-frame: y_valid=%0b s=%0d in_ready=%0b", y_valid, s, in_ready);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("t5.post");
        I = 8'h5A; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_cycle($sformatf("t5.n%0d", k), k, exp_5a[k], k == 7);
            $display("t5 bit s=%0d y=%0b", s, y);
            @(negedge clk);
        end
        chk_idle("t5.after");
`else
        // Test 6: parity frame 8'h07
        I = 8'h07; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk_cycle($sformatf("t6.b%0d", k), (k < 8) ? k : 7, exp_07[k], k == 8);
            $display("t6 bit %0d s=%0d y=%0b frame_done=%0b", k, s, y, frame_done);
            @(negedge clk);
        end
        chk_idle("t6.after");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
